sisc_mc_ctrl: RTL and testbench

//  Multicycle SISC control FSM with memory wait-state handshake, early branch/NOOP retire,
//  HLT/fault stop states and a retired-instruction counter. Drives the SISC datapath
//  (register file, ALU, PC, IR, data memory) from the IR opcode/mm fields and ALU status.

---
 rtl/sisc_mc_ctrl.sv | 136 +++++++++++++
 tb/tb_sisc_mc_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mc_ctrl.sv
// sisc_mc_ctrl: multicycle SISC control FSM with memory wait states, fault timeout and retire counter
module sisc_mc_ctrl #(
    parameter int OP_W     = 4,
    parameter int CC_W     = 4,
    parameter int IMM_MM   = 8,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OP_W-1:0]  opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [1:0]       alu_op,
    output logic             rb_sel,
    output logic             pc_sel,
    output logic             pc_write,
    output logic             pc_rst,
    output logic             ir_load,
    output logic             br_sel,
    output logic             mux_16_sel,
    output logic             dm_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam int WAIT_W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire, taken, timeout;

    always_comb begin
        mem_req    = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        alu_op     = 2'b00;
        rb_sel     = 1'b0;
        pc_sel     = 1'b0;
        pc_write   = 1'b0;
        pc_rst     = 1'b0;
        ir_load    = 1'b0;
        br_sel     = 1'b0;
        mux_16_sel = 1'b0;
        dm_we      = 1'b0;
        state_d    = state_q;
        wait_d     = '0;
        retire     = 1'b0;
        wait_inc   = wait_q + 1'b1;
        timeout    = (MAX_WAIT != 0) && (wait_inc == WAIT_W'(MAX_WAIT));
        taken      = (opcode == OP_BNE || opcode == OP_BNR) ? ((stat & mm) == '0) : ((stat & mm) != '0);
        halted     = (state_q == S_HALT) || (state_q == S_FAULT);
        fault      = state_q == S_FAULT;
        case (state_q)
            S_START: begin
                pc_rst  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_load  = mem_rdy;
                pc_write = mem_rdy;
                state_d  = mem_rdy ? S_DECODE : timeout ? S_FAULT : S_FETCH;
                wait_d   = (mem_rdy || timeout) ? '0 : wait_inc;
            end
            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (opcode inside {OP_ALU, OP_LOD, OP_STR}) begin
                    state_d = S_EXEC;
                end else begin
                    br_sel = opcode inside {OP_BRA, OP_BNE};
                    if (opcode inside {OP_BRA, OP_BRR, OP_BNE, OP_BNR} && taken) begin
                        pc_sel   = 1'b1;
                        pc_write = 1'b1;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op  = {opcode != OP_ALU, mm == CC_W'(IMM_MM)};
                state_d = (opcode == OP_ALU) ? S_WB : S_MEM;
            end
            S_MEM: begin
                mem_req    = 1'b1;
                mux_16_sel = mm == '0;
                alu_op     = {opcode != OP_ALU, mm == CC_W'(IMM_MM)};
                rb_sel     = opcode == OP_STR;
                dm_we      = opcode == OP_STR;
                retire     = mem_rdy && (opcode == OP_STR);
                state_d    = mem_rdy ? ((opcode == OP_STR) ? S_FETCH : S_WB) : timeout ? S_FAULT : S_MEM;
                wait_d     = (mem_rdy || timeout) ? '0 : wait_inc;
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = opcode == OP_LOD;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT, S_FAULT: state_d = state_q;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= S_START;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// tb_sisc_mc_ctrl: directed-vector bench for sisc_mc_ctrl
module tb_sisc_mc_ctrl;
    // packed outputs: {mem_req,rf_we,wb_sel}_{alu_op}_{rb_sel,pc_sel,pc_write,pc_rst}_{ir_load,br_sel,mux_16_sel,dm_we}_{halted,fault}
    localparam logic [14:0] V_START    = 15'b000_00_0001_0000_00;
    localparam logic [14:0] V_FRDY     = 15'b100_00_0010_1000_00;
    localparam logic [14:0] V_FWAIT    = 15'b100_00_0000_0000_00;
    localparam logic [14:0] V_ZERO     = 15'b000_00_0000_0000_00;
    localparam logic [14:0] V_WB_ALU   = 15'b010_00_0000_0000_00;
    localparam logic [14:0] V_WB_LOD   = 15'b011_00_0000_0000_00;
    localparam logic [14:0] V_EX_LODI  = 15'b000_11_0000_0000_00;
    localparam logic [14:0] V_MEM_LODI = 15'b100_11_0000_0000_00;
    localparam logic [14:0] V_EX_STR   = 15'b000_10_0000_0000_00;
    localparam logic [14:0] V_MEM_STR  = 15'b100_10_1000_0011_00;
    localparam logic [14:0] V_BR_ABS   = 15'b000_00_0110_0100_00;
    localparam logic [14:0] V_BR_REL   = 15'b000_00_0110_0000_00;
    localparam logic [14:0] V_HALT     = 15'b000_00_0000_0000_10;
    localparam logic [14:0] V_FAULT    = 15'b000_00_0000_0000_11;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  opcode, mm, stat;
    logic        mem_rdy;
    logic        mem_req, rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load;
    logic        br_sel, mux_16_sel, dm_we, halted, fault;
    logic [1:0]  alu_op;
    logic [15:0] instr_cnt;
    logic        x_mem_req, x_rf_we, x_wb_sel, x_rb_sel, x_pc_sel, x_pc_write, x_pc_rst, x_ir_load;
    logic        x_br_sel, x_mux_16_sel, x_dm_we, x_halted, x_fault;
    logic [1:0]  x_alu_op;
    logic [3:0]  x_instr_cnt;
    logic [14:0] outs;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sisc_mc_ctrl dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op), .rb_sel(rb_sel),
        .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load), .br_sel(br_sel),
        .mux_16_sel(mux_16_sel), .dm_we(dm_we), .halted(halted), .fault(fault), .instr_cnt(instr_cnt)
    );

    sisc_mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
        .mem_req(x_mem_req), .rf_we(x_rf_we), .wb_sel(x_wb_sel), .alu_op(x_alu_op), .rb_sel(x_rb_sel),
        .pc_sel(x_pc_sel), .pc_write(x_pc_write), .pc_rst(x_pc_rst), .ir_load(x_ir_load), .br_sel(x_br_sel),
        .mux_16_sel(x_mux_16_sel), .dm_we(x_dm_we), .halted(x_halted), .fault(x_fault), .instr_cnt(x_instr_cnt)
    );

    assign outs = {mem_req, rf_we, wb_sel, alu_op, rb_sel, pc_sel, pc_write, pc_rst,
                   ir_load, br_sel, mux_16_sel, dm_we, halted, fault};

    task automatic test_reset;
        rst_f = 1'b0; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_rdy = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_START) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", outs, V_START); end
        n_cmp++; if (instr_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", instr_cnt); end
        mem_rdy = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_START) begin n_err++; $display("FAIL reset_hold got=%b exp=%b", outs, V_START); end
    endtask

    task automatic test_alu;
        opcode = 4'd8; mm = 4'd0; rst_f = 1'b1; #1;
        n_cmp++; if (outs !== V_START) begin n_err++; $display("FAIL alu_start got=%b exp=%b", outs, V_START); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_FRDY) begin n_err++; $display("FAIL alu_fetch got=%b exp=%b", outs, V_FRDY); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_ZERO) begin n_err++; $display("FAIL alu_decode got=%b exp=%b", outs, V_ZERO); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_ZERO) begin n_err++; $display("FAIL alu_exec got=%b exp=%b", outs, V_ZERO); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_WB_ALU) begin n_err++; $display("FAIL alu_wb got=%b exp=%b", outs, V_WB_ALU); end
        n_cmp++; if (instr_cnt !== 16'd0) begin n_err++; $display("FAIL alu_cnt_wb got=%0d exp=0", instr_cnt); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_FRDY) begin n_err++; $display("FAIL alu_refetch got=%b exp=%b", outs, V_FRDY); end
        n_cmp++; if (instr_cnt !== 16'd1) begin n_err++; $display("FAIL alu_cnt got=%0d exp=1", instr_cnt); end
    endtask

    task automatic test_lod_str;
        opcode = 4'd1; mm = 4'd8; #1;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_ZERO) begin n_err++; $display("FAIL lod_decode got=%b exp=%b", outs, V_ZERO); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_EX_LODI) begin n_err++; $display("FAIL lod_exec got=%b exp=%b", outs, V_EX_LODI); end
        @(negedge clk); mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_rdy = 1'b1;
            #1;
            n_cmp++; if (outs !== V_MEM_LODI) begin n_err++; $display("FAIL lod_mem%0d got=%b exp=%b", i, outs, V_MEM_LODI); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (outs !== V_WB_LOD) begin n_err++; $display("FAIL lod_wb got=%b exp=%b", outs, V_WB_LOD); end
        @(negedge clk); #1;
        n_cmp++; if (instr_cnt !== 16'd2) begin n_err++; $display("FAIL lod_cnt got=%0d exp=2", instr_cnt); end
        opcode = 4'd2; mm = 4'd0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (outs !== V_EX_STR) begin n_err++; $display("FAIL str_exec got=%b exp=%b", outs, V_EX_STR); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_MEM_STR) begin n_err++; $display("FAIL str_mem got=%b exp=%b", outs, V_MEM_STR); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_FRDY) begin n_err++; $display("FAIL str_refetch got=%b exp=%b", outs, V_FRDY); end
        n_cmp++; if (instr_cnt !== 16'd3) begin n_err++; $display("FAIL str_cnt got=%0d exp=3", instr_cnt); end
    endtask

    task automatic test_branch;
        opcode = 4'd6; mm = 4'b0100; stat = 4'b0010;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_BR_ABS) begin n_err++; $display("FAIL bne_taken got=%b exp=%b", outs, V_BR_ABS); end
        @(negedge clk); #1;
        n_cmp++; if (instr_cnt !== 16'd4) begin n_err++; $display("FAIL bne_cnt got=%0d exp=4", instr_cnt); end
        opcode = 4'd5;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_ZERO) begin n_err++; $display("FAIL brr_not_taken got=%b exp=%b", outs, V_ZERO); end
        @(negedge clk); opcode = 4'd4; stat = 4'b0110;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_BR_ABS) begin n_err++; $display("FAIL bra_taken got=%b exp=%b", outs, V_BR_ABS); end
        @(negedge clk); opcode = 4'd7; stat = 4'b0010;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_BR_REL) begin n_err++; $display("FAIL bnr_taken got=%b exp=%b", outs, V_BR_REL); end
        @(negedge clk); #1;
        n_cmp++; if (instr_cnt !== 16'd7) begin n_err++; $display("FAIL branch_cnt got=%0d exp=7", instr_cnt); end
    endtask

    task automatic test_fault;
        opcode = 4'd0; mem_rdy = 1'b0;
        repeat (14) @(negedge clk);
        mem_rdy = 1'b1; #1;
        n_cmp++; if (outs !== V_FRDY) begin n_err++; $display("FAIL wait14_fetch got=%b exp=%b", outs, V_FRDY); end
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_ZERO) begin n_err++; $display("FAIL wait14_decode got=%b exp=%b", outs, V_ZERO); end
        @(negedge clk); mem_rdy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            n_cmp++; if (outs !== V_FWAIT) begin n_err++; $display("FAIL wait_cycle%0d got=%b exp=%b", i, outs, V_FWAIT); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (outs !== V_FAULT) begin n_err++; $display("FAIL fault_enter got=%b exp=%b", outs, V_FAULT); end
        mem_rdy = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_FAULT) begin n_err++; $display("FAIL fault_sticky got=%b exp=%b", outs, V_FAULT); end
        n_cmp++; if (instr_cnt !== 16'd8) begin n_err++; $display("FAIL fault_cnt got=%0d exp=8", instr_cnt); end
        rst_f = 1'b0; #1;
        n_cmp++; if (outs !== V_START) begin n_err++; $display("FAIL fault_reset got=%b exp=%b", outs, V_START); end
        n_cmp++; if (instr_cnt !== 16'd0) begin n_err++; $display("FAIL fault_reset_cnt got=%0d exp=0", instr_cnt); end
        @(negedge clk); rst_f = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (outs !== V_FRDY) begin n_err++; $display("FAIL fault_restart got=%b exp=%b", outs, V_FRDY); end
    endtask

    task automatic test_halt_reset;
        opcode = 4'd15;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (outs !== V_HALT) begin n_err++; $display("FAIL halt_enter got=%b exp=%b", outs, V_HALT); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (outs !== V_HALT) begin n_err++; $display("FAIL halt_sticky got=%b exp=%b", outs, V_HALT); end
        n_cmp++; if (instr_cnt !== 16'd0) begin n_err++; $display("FAIL halt_cnt got=%0d exp=0", instr_cnt); end
        rst_f = 1'b0;
        @(negedge clk); rst_f = 1'b1; opcode = 4'd0;
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (instr_cnt !== 16'd1) begin n_err++; $display("FAIL noop_cnt got=%0d exp=1", instr_cnt); end
        opcode = 4'd2; mm = 4'd0;
        @(negedge clk); @(negedge clk); @(negedge clk); mem_rdy = 1'b0; #1;
        n_cmp++; if (outs !== V_MEM_STR) begin n_err++; $display("FAIL str_mem_wait got=%b exp=%b", outs, V_MEM_STR); end
        rst_f = 1'b0; #1;
        n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL str_abort_dm_we got=%b exp=0", dm_we); end
        n_cmp++; if (outs !== V_START) begin n_err++; $display("FAIL str_abort got=%b exp=%b", outs, V_START); end
        n_cmp++; if (instr_cnt !== 16'd0) begin n_err++; $display("FAIL str_abort_cnt got=%0d exp=0", instr_cnt); end
        @(negedge clk); rst_f = 1'b1; mem_rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        for (int i = 1; i <= 16; i++) begin
            opcode = (i == 1) ? 4'd3 : 4'd0;
            @(negedge clk); #1;
            if (i == 1) begin
                n_cmp++; if (outs !== V_ZERO) begin n_err++; $display("FAIL swp_decode got=%b exp=%b", outs, V_ZERO); end
            end
            @(negedge clk); #1;
            n_cmp++; if (instr_cnt !== 16'(i)) begin n_err++; $display("FAIL wrap_cnt16_%0d got=%0d exp=%0d", i, instr_cnt, i); end
            n_cmp++; if (x_instr_cnt !== 4'(i % 16)) begin n_err++; $display("FAIL wrap_cnt4_%0d got=%0d exp=%0d", i, x_instr_cnt, i % 16); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_lod_str();
        test_branch();
        test_fault();
        test_halt_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
